// File: rtl/qspi_flash_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : qspi_flash_reader_if
// Desc     : Request/response handshake between XIP line-fill and QSPI reader.
// Revision : 1.0
// ============================================================================
interface qspi_flash_reader_if;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        busy;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_done;

  modport master (
    output rd_req, rd_addr,
    input  busy, rd_data, rd_valid, rd_done
  );

  modport slave (
    input  rd_req, rd_addr,
    output busy, rd_data, rd_valid, rd_done
  );
endinterface
`default_nettype wire

// File: rtl/qspi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : qspi_flash_reader
// Desc     : Quad I/O Fast Read (0xEB) burst engine for SPI NOR flash.
//            Optional macro FR_CONT_READ_EN: mode byte 0xA0 and CMD skipped
//            on every transaction after the first completed one.
// Revision : 1.0
// ============================================================================
module qspi_flash_reader #(
  parameter int NUM_WORDS    = 4,
  parameter int DUMMY_CYCLES = 4,
  parameter int CEH_CYCLES   = 2
) (
  input  wire logic          HCLK,
  input  wire logic          HRESET,
  qspi_flash_reader_if.slave rd,
  output logic               fr_sck,
  output logic               fr_ce_n,
  output logic [3:0]         fr_dout,
  output logic               fr_douten,
  input  wire logic [3:0]    fr_din
);

  localparam logic [2:0] c_st_rst_seq = 3'd0;
  localparam logic [2:0] c_st_idle    = 3'd1;
  localparam logic [2:0] c_st_cmd     = 3'd2;
  localparam logic [2:0] c_st_addr    = 3'd3;
  localparam logic [2:0] c_st_mode    = 3'd4;
  localparam logic [2:0] c_st_dummy   = 3'd5;
  localparam logic [2:0] c_st_data    = 3'd6;
  localparam logic [2:0] c_st_ceh     = 3'd7;

  localparam logic [7:0] c_cmd        = 8'hEB;
  localparam logic [7:0] c_dummy_last = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] c_data_last  = 8'(8 * NUM_WORDS - 1);
  localparam logic [7:0] c_ceh_last   = 8'(CEH_CYCLES - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        r_half;
  logic [7:0]  r_cnt;
  logic        r_arm;
  logic [23:0] r_addr;
  logic [27:0] r_shift;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_done;
  logic        w_skip_cmd;
  logic        w_shifting;
  logic [7:0]  w_last;
  logic        w_sck_end;
  logic        w_nib_end;
  logic        w_word_end;
  logic [31:0] w_word;

`ifdef FR_CONT_READ_EN
  localparam logic [7:0] c_mode = 8'hA0;
  logic r_cont;

  // Flash stays in continuous-read mode once a 0xA0 transaction has completed.
  always_ff @(posedge HCLK) begin
    if (HRESET)
      r_cont <= 1'b0;
    else if (r_state == c_st_data && w_state_nxt == c_st_ceh)
      r_cont <= 1'b1;
  end
  assign w_skip_cmd = r_cont;
`else
  localparam logic [7:0] c_mode = 8'hFF;
  assign w_skip_cmd = 1'b0;
`endif

  // r_half=0 is the SCK-low half; RST_SEQ idles one cycle (r_arm=0) so reset values show first.
  assign w_shifting = (r_state == c_st_rst_seq) ? r_arm
                    : (r_state != c_st_idle) && (r_state != c_st_ceh);

  always_comb begin
    w_last = 8'd0;
    case (r_state)
      c_st_rst_seq: w_last = 8'd7;
      c_st_cmd:     w_last = 8'd7;
      c_st_addr:    w_last = 8'd5;
      c_st_mode:    w_last = 8'd1;
      c_st_dummy:   w_last = c_dummy_last;
      c_st_data:    w_last = c_data_last;
      c_st_ceh:     w_last = c_ceh_last;
      default:      w_last = 8'd0;
    endcase
  end

  assign w_sck_end  = w_shifting && r_half && (r_cnt == w_last);
  assign w_nib_end  = (r_state == c_st_data) && r_half;
  assign w_word_end = w_nib_end && (r_cnt[2:0] == 3'd7);
  assign w_word     = {r_shift, fr_din};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= c_st_rst_seq;
      r_half  <= 1'b0;
      r_cnt   <= 8'd0;
      r_arm   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_st_rst_seq)
        r_arm <= 1'b1;
      if (w_state_nxt != r_state) begin
        r_half <= 1'b0;
        r_cnt  <= 8'd0;
      end else if (w_shifting) begin
        r_half <= ~r_half;
        if (r_half)
          r_cnt <= r_cnt + 8'd1;
      end else if (r_state == c_st_ceh) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_rst_seq: if (w_sck_end) w_state_nxt = c_st_ceh;
      c_st_idle:    if (rd.rd_req) w_state_nxt = w_skip_cmd ? c_st_addr : c_st_cmd;
      c_st_cmd:     if (w_sck_end) w_state_nxt = c_st_addr;
      c_st_addr:    if (w_sck_end) w_state_nxt = c_st_mode;
      c_st_mode:    if (w_sck_end) w_state_nxt = c_st_dummy;
      c_st_dummy:   if (w_sck_end) w_state_nxt = c_st_data;
      c_st_data:    if (w_sck_end) w_state_nxt = c_st_ceh;
      c_st_ceh:     if (r_cnt == w_last) w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    fr_ce_n   = 1'b1;
    fr_sck    = 1'b0;
    fr_dout   = 4'hF;
    fr_douten = 1'b0;
    case (r_state)
      c_st_rst_seq: begin
        if (r_arm) begin
          fr_ce_n   = 1'b0;
          fr_sck    = r_half;
          fr_douten = 1'b1;
        end
      end
      c_st_cmd: begin
        fr_ce_n   = 1'b0;
        fr_sck    = r_half;
        fr_douten = 1'b1;
        fr_dout   = {3'b110, c_cmd[3'd7 - r_cnt[2:0]]};
      end
      c_st_addr: begin
        fr_ce_n   = 1'b0;
        fr_sck    = r_half;
        fr_douten = 1'b1;
        fr_dout   = r_addr[23:20];
      end
      c_st_mode: begin
        fr_ce_n   = 1'b0;
        fr_sck    = r_half;
        fr_douten = 1'b1;
        fr_dout   = r_cnt[0] ? c_mode[3:0] : c_mode[7:4];
      end
      c_st_dummy, c_st_data: begin
        fr_ce_n = 1'b0;
        fr_sck  = r_half;
      end
      default: ;
    endcase
  end

  // Nibbles shift in MSB-first; the byte swap gives little-endian packing.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_addr  <= 24'd0;
      r_shift <= 28'd0;
      r_data  <= 32'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_word_end;
      r_done  <= w_word_end && (r_cnt == c_data_last);
      if (r_state == c_st_idle && rd.rd_req)
        r_addr <= {rd.rd_addr[23:2], rd.rd_addr[1:0] & 2'b00};
      else if (r_state == c_st_addr && r_half)
        r_addr <= {r_addr[19:0], 4'h0};
      if (w_nib_end)
        r_shift <= w_word[27:0];
      if (w_word_end)
        r_data <= {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};
    end
  end

  assign rd.busy     = (r_state != c_st_idle);
  assign rd.rd_data  = r_data;
  assign rd.rd_valid = r_valid;
  assign rd.rd_done  = r_done;

endmodule
`default_nettype wire
